pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter IMEM_TIMEOUT, default 15: the number of FETCH cycles without imem_ack after which the block enters FAULT.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_ack  input  1  instruction memory has `instr` valid this cycle.
REQ-005 instr  input  32  instruction word from instruction memory.
REQ-006 alu_zero  input  1  ALU zero flag, valid in EXEC.
REQ-007 dmem_ack  input  1  data memory has completed the access this cycle.
REQ-008 imem_req  output  1  instruction fetch request.
REQ-009 ir_load  output  1  one-cycle strobe that captures `instr` into the instruction register.
REQ-010 pc_update  output  1  one-cycle enable for the PC register.
REQ-011 pcsel  output  1  branch select: next PC = PC + offset + 1.
REQ-012 jump  output  1  jump select: next PC = target.
REQ-013 jal  output  1  jump-and-link qualifier.
REQ-014 link_write  output  1  write PC+1 to r31.
REQ-015 reg_write  output  1  register file write enable.
REQ-016 mem_read  output  1  data memory read request.
REQ-017 mem_write  output  1  data memory write request.
REQ-018 state  output  3  current state encoding.
REQ-019 retired  output  32  count of retired instructions.
REQ-020 fault  output  1  sticky error flag.

Function
REQ-021 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; code 7 SHALL transition to FAULT.
REQ-022 The instruction register SHALL be internal, loaded when ir_load=1; decode SHALL use opcode IR[31:26] and funct IR[5:0].
REQ-023 All outputs except `state` and `retired` SHALL be combinational decodes of the registered state, IR and inputs.
REQ-024 FETCH: imem_req=1; on imem_ack: ir_load=1, timeout counter cleared, next state DECODE; otherwise the counter increments.
REQ-025 FETCH: when the counter reaches IMEM_TIMEOUT with imem_ack=0, the next state SHALL be FAULT; an ack in that same cycle SHALL win.
REQ-026 DECODE: IR=32'hFFFFFFFF -> HALT; unsupported opcode -> FAULT; otherwise -> EXEC; decode takes one cycle.
REQ-027 Supported instructions SHALL be: R-type 000000 (jr when funct=001000), addi 001000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
REQ-028 EXEC, beq/bne: pc_update=1 and pcsel=alu_zero (beq) or ~alu_zero (bne); next state FETCH.
REQ-029 EXEC, j/jr: pc_update=1 and jump=1; next state FETCH.
REQ-030 EXEC, jal: pc_update=1, jump=1, jal=1 and link_write=1, all in one cycle; next state FETCH.
REQ-031 EXEC, R-type (other than jr) and addi: next state WB; lw/sw: next state MEM.
REQ-032 MEM: mem_read (lw) or mem_write (sw) SHALL be held high until dmem_ack, with no timeout.
REQ-033 MEM, on dmem_ack: lw -> WB; sw -> pc_update=1 and next state FETCH.
REQ-034 WB: reg_write=1 and pc_update=1 with pcsel=0; next state FETCH.
REQ-035 pcsel, jump, jal and link_write SHALL be 0 whenever pc_update=0, and pcsel and jump SHALL never both be 1.
REQ-036 retired SHALL increment by 1, wrapping mod 2^32, on every cycle with pc_update=1.
REQ-037 HALT and FAULT SHALL be absorbing until reset, with every strobe output 0 in those states; fault=1 in FAULT.

Reset
REQ-038 While reset=1, every output except `state` SHALL be 0 in that cycle.
REQ-039 After the reset edge: state=FETCH, IR=0, retired=0, timeout counter=0, fault=0.
REQ-040 Reset SHALL override any in-progress fetch, memory wait or FAULT/HALT state at the next edge, with no pc_update issued.

Verification
REQ-041 beq with alu_zero=1 after imem_ack in cycle 1 -> DECODE, EXEC; pc_update=pcsel=1 in cycle 3; retired=1.
REQ-042 lw with dmem_ack delayed 4 cycles -> mem_read high for 4 cycles, then WB with reg_write=pc_update=1; retired increments once.
REQ-043 jal 32'h0C000010 -> one EXEC cycle with jump=jal=link_write=pc_update=1 and pcsel=0.
REQ-044 imem_ack held 0 -> FAULT after 15 FETCH cycles, fault=1; reset then gives state=0 and fault=0.
REQ-045 instr=32'hFFFFFFFF -> HALT, with no pc_update for 20 subsequent cycles.
REQ-046 reset asserted mid-MEM -> mem_read=0 in that cycle; state=FETCH next; retired=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle control sequencer: fetch, decode, execute, memory and writeback for a small MIPS-like subset.
// Latency: branch/jump retire 2 cycles after the fetch ack, ALU ops 3, loads 3+N and stores 2+N for N memory wait cycles.
// Backpressure: stalls in FETCH until imem_ack (faulting after IMEM_TIMEOUT cycles) and in MEM until dmem_ack with no timeout.
module pc_sequencer #(
    parameter int IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_update,
    output logic        pcsel,
    output logic        jump,
    output logic        jal,
    output logic        link_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  state,
    output logic [31:0] retired,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_FAULT   = 3'd6,
        S_ILLEGAL = 3'd7
    } state_t;

    // Instruction classes after decode; K_BAD covers every opcode outside the supported subset.
    typedef enum logic [3:0] {
        K_ALU, K_JR, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_BAD
    } kind_t;

    localparam int TW = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(IMEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     ir_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [31:0]     retired_q;
    kind_t           kind;

    // Ungated control decodes; reset masking is applied at the ports.
    logic            imem_req_raw;
    logic            ir_load_raw;
    logic            pc_update_raw;
    logic            pcsel_raw;
    logic            jump_raw;
    logic            jal_raw;
    logic            link_write_raw;
    logic            reg_write_raw;
    logic            mem_read_raw;
    logic            mem_write_raw;
    logic            fault_raw;
    logic            tmo_clr;
    logic            tmo_inc;

    // Classify the held instruction by opcode, with jr split out of the R-type group by funct.
    always_comb begin
        kind = K_BAD;
        case (ir_q[31:26])
            OP_RTYPE: kind = (ir_q[5:0] == FN_JR) ? K_JR : K_ALU;
            OP_ADDI:  kind = K_ALU;
            OP_LW:    kind = K_LW;
            OP_SW:    kind = K_SW;
            OP_BEQ:   kind = K_BEQ;
            OP_BNE:   kind = K_BNE;
            OP_J:     kind = K_J;
            OP_JAL:   kind = K_JAL;
            default:  kind = K_BAD;
        endcase
    end

    // Next-state and control strobes; every strobe defaults low so HALT/FAULT stay quiet.
    always_comb begin
        state_d        = state_q;
        imem_req_raw   = 1'b0;
        ir_load_raw    = 1'b0;
        pc_update_raw  = 1'b0;
        pcsel_raw      = 1'b0;
        jump_raw       = 1'b0;
        jal_raw        = 1'b0;
        link_write_raw = 1'b0;
        reg_write_raw  = 1'b0;
        mem_read_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        fault_raw      = 1'b0;
        tmo_clr        = 1'b0;
        tmo_inc        = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_raw = 1'b1;
                // An ack arriving on the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_load_raw = 1'b1;
                    tmo_clr     = 1'b1;
                    state_d     = S_DECODE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_DECODE: begin
                if (ir_q == 32'hFFFF_FFFF) begin
                    state_d = S_HALT;
                end else if (kind == K_BAD) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (kind)
                    K_BEQ: begin
                        pc_update_raw = 1'b1;
                        pcsel_raw     = alu_zero;
                        state_d       = S_FETCH;
                    end
                    K_BNE: begin
                        pc_update_raw = 1'b1;
                        pcsel_raw     = ~alu_zero;
                        state_d       = S_FETCH;
                    end
                    K_J, K_JR: begin
                        pc_update_raw = 1'b1;
                        jump_raw      = 1'b1;
                        state_d       = S_FETCH;
                    end
                    K_JAL: begin
                        pc_update_raw  = 1'b1;
                        jump_raw       = 1'b1;
                        jal_raw        = 1'b1;
                        link_write_raw = 1'b1;
                        state_d        = S_FETCH;
                    end
                    K_ALU:      state_d = S_WB;
                    K_LW, K_SW: state_d = S_MEM;
                    default:    state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                mem_read_raw  = (kind == K_LW);
                mem_write_raw = (kind == K_SW);
                if (dmem_ack) begin
                    if (kind == K_LW) begin
                        state_d = S_WB;
                    end else begin
                        pc_update_raw = 1'b1;
                        state_d       = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write_raw = 1'b1;
                pc_update_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            S_FAULT: begin
                fault_raw = 1'b1;
                state_d   = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // State, instruction register, fetch timeout counter and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ir_q      <= 32'd0;
            tmo_cnt_q <= '0;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (ir_load_raw) begin
                ir_q <= instr;
            end
            if (tmo_clr) begin
                tmo_cnt_q <= '0;
            end else if (tmo_inc) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (pc_update_raw) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    // While reset is high every output except the state code is forced low in the same cycle.
    assign imem_req   = ~reset & imem_req_raw;
    assign ir_load    = ~reset & ir_load_raw;
    assign pc_update  = ~reset & pc_update_raw;
    assign pcsel      = ~reset & pcsel_raw;
    assign jump       = ~reset & jump_raw;
    assign jal        = ~reset & jal_raw;
    assign link_write = ~reset & link_write_raw;
    assign reg_write  = ~reset & reg_write_raw;
    assign mem_read   = ~reset & mem_read_raw;
    assign mem_write  = ~reset & mem_write_raw;
    assign fault      = ~reset & fault_raw;
    assign retired    = reset ? 32'd0 : retired_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench: a fetch driver issues instructions and pushes predicted retire events, a monitor pops them on pc_update.
// Latency: predictions carry the exact cycle of retirement derived from instruction class and memory wait.
// Backpressure: imem/dmem acks are delayed randomly; directed sections cover halt, timeout, illegal opcode and reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        alu_zero = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, ir_load, pc_update, pcsel, jump, jal, link_write;
    logic        reg_write, mem_read, mem_write, fault;
    logic [2:0]  state;
    logic [31:0] retired;

    pc_sequencer #(.IMEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .imem_ack(imem_ack), .instr(instr),
        .alu_zero(alu_zero), .dmem_ack(dmem_ack), .imem_req(imem_req),
        .ir_load(ir_load), .pc_update(pc_update), .pcsel(pcsel), .jump(jump),
        .jal(jal), .link_write(link_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .state(state),
        .retired(retired), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit pcsel;
        bit jump;
        bit jal;
        bit link;
        bit regw;
        int nrd;
        int nwr;
    } exp_t;

    exp_t sb[$];
    int   nchecks = 0;
    int   nfails = 0;
    int   cyc = 0;
    int   mem_dly = 1;
    int   mcnt = 0;
    int   exp_ret = 0;
    int   nrd = 0;
    int   nwr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what an instruction must do when it retires, from the instruction-set rules alone.
    function automatic exp_t model(input logic [31:0] w, input bit az, input int dd, input int c);
        exp_t e;
        e = '{cyc: c + 2, pcsel: 0, jump: 0, jal: 0, link: 0, regw: 0, nrd: 0, nwr: 0};
        case (w[31:26])
            6'd0: if (w[5:0] == 6'd8) e.jump = 1; else begin e.regw = 1; e.cyc = c + 3; end
            6'd8: begin e.regw = 1; e.cyc = c + 3; end
            6'd35: begin e.regw = 1; e.cyc = c + 3 + dd; e.nrd = dd; end
            6'd43: begin e.cyc = c + 2 + dd; e.nwr = dd; end
            6'd4: e.pcsel = az;
            6'd5: e.pcsel = !az;
            6'd2: e.jump = 1;
            6'd3: begin e.jump = 1; e.jal = 1; e.link = 1; end
            default: e.cyc = -1;
        endcase
        return e;
    endfunction

    // Data memory responder: acks on the dd-th consecutive cycle of a memory request.
    always @(posedge clk) begin
        #1;
        if (mem_read || mem_write) begin
            mcnt++;
            dmem_ack = (mcnt == mem_dly);
        end else begin
            mcnt = 0;
            dmem_ack = 1'b0;
        end
    end

    // Monitor: reset masking, per-cycle select invariants, retire count, and scoreboard pops on pc_update.
    always @(negedge clk) begin
        if (reset) begin
            check("reset_strobes", {21'd0, imem_req, ir_load, pc_update, pcsel, jump, jal,
                  link_write, reg_write, mem_read, mem_write, fault}, 32'd0);
            check("reset_retired", retired, 32'd0);
            sb.delete();
            exp_ret = 0;
            nrd = 0;
            nwr = 0;
        end else begin
            check("retired", retired, exp_ret);
            if (!pc_update) check("selects_idle", {28'd0, pcsel, jump, jal, link_write}, 32'd0);
            check("pcsel_jump_excl", {31'd0, pcsel & jump}, 32'd0);
            if (mem_read) nrd++;
            if (mem_write) nwr++;
            if (pc_update) begin
                if (sb.size() == 0) begin
                    check("unexpected_pc_update", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("retire_cycle", cyc, e.cyc);
                    check("retire_flags", {27'd0, pcsel, jump, jal, link_write, reg_write},
                          {27'd0, e.pcsel, e.jump, e.jal, e.link, e.regw});
                    check("mem_read_cycles", nrd, e.nrd);
                    check("mem_write_cycles", nwr, e.nwr);
                end
                nrd = 0;
                nwr = 0;
                exp_ret++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a fetch request, hold off the ack for adly cycles, then present the word.
    task automatic fetch(input logic [31:0] w, input int adly, input bit az, input int dd, input bit push);
        int n = 0;
        while (!imem_req && n < 200) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            check("fetch_wait_timeout", 32'd1, 32'd0);
            return;
        end
        for (int i = 0; i < adly; i++) tick();
        instr = w;
        alu_zero = az;
        mem_dly = dd;
        imem_ack = 1'b1;
        if (push) sb.push_back(model(w, az, dd, cyc));
        tick();
        imem_ack = 1'b0;
        instr = $urandom;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_state", {29'd0, state}, 32'd0);
        check("post_reset_retired", retired, 32'd0);
        check("post_reset_fault", {31'd0, fault}, 32'd0);
        check("post_reset_imem_req", {31'd0, imem_req}, 32'd1);
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [8];
        logic [31:0] w;
        ops = '{6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};
        w = $urandom;
        w[31:26] = ops[$urandom_range(0, 7)];
        if (w[31:26] == 6'd0 && $urandom_range(0, 2) == 0) w[5:0] = 6'd8;
        return w;
    endfunction

    initial begin
        int n;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("init_state", {29'd0, state}, 32'd0);
        check("init_retired", retired, 32'd0);
        tick();

        // Directed: beq taken, bne not taken, lw with 4-cycle wait, jal, sw, addi, jr.
        fetch(32'h1000_0004, 0, 1'b1, 1, 1'b1);
        fetch(32'h1400_0004, 0, 1'b1, 1, 1'b1);
        fetch(32'h8C00_0000, 1, 1'b0, 4, 1'b1);
        fetch(32'h0C00_0010, 2, 1'b0, 1, 1'b1);
        fetch(32'hAC00_0000, 0, 1'b0, 2, 1'b1);
        fetch(32'h2000_0001, 3, 1'b0, 1, 1'b1);
        fetch(32'h03E0_0008, 0, 1'b0, 1, 1'b1);

        // Randomized instruction stream with random ack delays and ALU flag.
        for (int i = 0; i < 250; i++) begin
            fetch(rand_instr(), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 6), 1'b1);
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);

        // All-ones word halts with no further retirement.
        fetch(32'hFFFF_FFFF, 0, 1'b0, 1, 1'b0);
        tick();
        repeat (20) begin
            @(negedge clk);
            check("halt_state", {29'd0, state}, 32'd5);
            check("halt_quiet", {30'd0, pc_update, imem_req}, 32'd0);
        end

        // Fetch timeout: 15 FETCH cycles without ack, then sticky FAULT.
        do_reset();
        repeat (14) begin
            @(negedge clk);
            check("timeout_fetch", {29'd0, state}, 32'd0);
        end
        @(negedge clk);
        check("timeout_fault_state", {29'd0, state}, 32'd6);
        check("timeout_fault_flag", {31'd0, fault}, 32'd1);
        check("fault_quiet", {30'd0, imem_req, pc_update}, 32'd0);

        // Unsupported opcode faults out of DECODE.
        do_reset();
        fetch(32'h0400_0000, 0, 1'b0, 1, 1'b0);
        tick();
        @(negedge clk);
        check("illegal_op_state", {29'd0, state}, 32'd6);
        check("illegal_op_fault", {31'd0, fault}, 32'd1);

        // Reset during a stalled load.
        do_reset();
        fetch(32'h8C00_0000, 0, 1'b0, 100000, 1'b1);
        n = 0;
        while (!mem_read && n < 20) begin
            tick();
            n++;
        end
        check("reached_mem", {31'd0, mem_read}, 32'd1);
        repeat (2) tick();
        reset = 1'b1;
        @(negedge clk);
        check("midmem_mem_read", {31'd0, mem_read}, 32'd0);
        check("midmem_pc_update", {31'd0, pc_update}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midmem_state", {29'd0, state}, 32'd0);
        check("midmem_retired", retired, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
        $finish;
    end

endmodule
